bubsysrom_prom_loader: RTL and testbench
========================================

BUBSYSROM_PROM_LOADER -- requirements
Module: bubsysrom_prom_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  AW  10  PROM address width; each region is 2**AW bytes.
  DLAW  24  download byte-address width.
  BASE0 / BASE1 / BASE2 / BASE3  0 / 1024 / 2048 / 3072  download byte offset of PROM region 0..3.
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  i_MCLK  in  1  sole clock; all logic on rising edge.
  i_RST  in  1  reset, synchronous, active-high.
  i_DL_ACT  in  1  download session active.
  i_DL_ADDR  in  DLAW  download byte address, valid with i_DL_WR.
  i_DL_DATA  in  8  download byte, valid with i_DL_WR.
  i_DL_WR  in  1  one-cycle byte strobe.
  o_DL_WAIT  out  1  loader busy; source holds next strobe.
  o_PROG_ADDR  out  AW  PROM programming address.
  o_PROG_DIN  out  8  PROM programming data.
  o_PROG_CS  out  4  one-hot PROM select, bit n = region n.
  o_PROG_WR  out  1  PROM write strobe.
  o_BUSY  out  1  state is LOAD.
  o_DONE  out  1  sticky session-complete flag.
  o_ERR  out  1  sticky protocol-error flag.
  o_CHKSUM  out  8  mod-256 sum of bytes written this session.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, DONE.
REQ-004 IDLE->LOAD on i_DL_ACT high; entry clears o_DONE, o_ERR, o_CHKSUM.
REQ-005 In LOAD, i_DL_WR=1 with o_DL_WAIT=0 SHALL capture addr/data (accept cycle T).
REQ-006 Region n SHALL match when BASEn <= addr < BASEn+2**AW; lowest n wins on overlap.
REQ-007 In cycle T+1, matching accept: o_PROG_WR=1, o_PROG_CS one-hot bit n, o_PROG_ADDR=(addr-BASEn)[AW-1:0], o_PROG_DIN=data, exactly one cycle.
REQ-008 No matching region: o_PROG_WR and o_PROG_CS stay 0 in T+1; byte dropped silently, no checksum update.
REQ-009 o_DL_WAIT SHALL be 1 in T+1 only; max throughput one byte per 2 cycles.
REQ-010 i_DL_WR=1 while o_DL_WAIT=1 SHALL be ignored and set o_ERR.
REQ-011 o_CHKSUM SHALL add o_PROG_DIN mod 256 in each cycle o_PROG_WR=1, visible next cycle.
REQ-012 o_PROG_CS, o_PROG_WR SHALL be 0 in every cycle with no write; o_PROG_ADDR/o_PROG_DIN hold last value.
REQ-013 i_DL_ACT low in LOAD: LOAD->DONE once no write pending; strobe accepted same cycle as ACT fall still written at T+1, DONE entered at T+2.
REQ-014 DONE SHALL set o_DONE=1; DONE->LOAD on i_DL_ACT high (REQ-004 clears apply).
REQ-015 i_DL_WR in IDLE or DONE SHALL be ignored; no o_ERR.
REQ-016 o_BUSY=1 exactly while state is LOAD.

Reset
REQ-017 i_RST=1 at a rising edge SHALL force IDLE and zero all outputs, o_PROG_ADDR and o_PROG_DIN included.
REQ-018 Reset overrides all inputs; write pending at T+1 when reset samples SHALL be cancelled (o_PROG_WR=0).
REQ-019 Reset mid-session: after i_RST falls, loader stays IDLE until i_DL_ACT sampled high.

Verification
REQ-020 Bench SHALL cover:
  Byte 0x5A at addr 1030, defaults -> next cycle CS=0010, ADDR=6, DIN=0x5A, WR=1 one cycle; o_CHKSUM=0x5A.
  Bytes 0x01..0x04 at addrs 0, 1024, 2048, 3072 every 2 cycles -> CS 0001/0010/0100/1000 at ADDR 0; o_CHKSUM=0x0A; o_ERR=0.
  Strobe at addr 5000 -> no WR, no CS, checksum unchanged; strobe on back-to-back cycle -> o_ERR=1, second byte not written.
  ACT falls same cycle as strobe at addr 1 -> write at T+1; o_DONE=1, o_BUSY=0 at T+2; new ACT rise clears o_DONE/o_CHKSUM.
  i_RST in T+1 of accepted strobe -> no write; all outputs 0; strobes ignored until ACT sampled high.

Source files
------------

// File: rtl/bubsysrom_prom_loader.sv
// bubsysrom_prom_loader: routes download bytes into four PROM regions, one byte per two cycles
module bubsysrom_prom_loader #(
  parameter int AW    = 10,
  parameter int DLAW  = 24,
  parameter int BASE0 = 0,
  parameter int BASE1 = 1024,
  parameter int BASE2 = 2048,
  parameter int BASE3 = 3072
) (
  input  logic            i_MCLK,
  input  logic            i_RST,
  input  logic            i_DL_ACT,
  input  logic [DLAW-1:0] i_DL_ADDR,
  input  logic [7:0]      i_DL_DATA,
  input  logic            i_DL_WR,
  output logic            o_DL_WAIT,
  output logic [AW-1:0]   o_PROG_ADDR,
  output logic [7:0]      o_PROG_DIN,
  output logic [3:0]      o_PROG_CS,
  output logic            o_PROG_WR,
  output logic            o_BUSY,
  output logic            o_DONE,
  output logic            o_ERR,
  output logic [7:0]      o_CHKSUM
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [63:0] BASES [4] = '{64'(BASE0), 64'(BASE1), 64'(BASE2), 64'(BASE3)};
  localparam logic [63:0] SPAN = 64'(1) << AW;
  state_t        state_q;
  logic          wait_q, wr_q, done_q, err_q;
  logic [3:0]    cs_q, hit;
  logic [AW-1:0] addr_q, off;
  logic [7:0]    din_q, sum_q;
  logic [63:0]   a;
  logic          acc;
  assign a   = 64'(i_DL_ADDR);
  assign acc = (state_q == LOAD) && i_DL_WR && !wait_q;
  // descending scan so the lowest matching region overwrites the others
  always_comb begin
    hit = '0;
    off = '0;
    for (int n = 3; n >= 0; n--)
      if (a >= BASES[n] && a < BASES[n] + SPAN) begin
        hit = 4'(1 << n);
        off = AW'(a - BASES[n]);
      end
  end
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wait_q <= acc;
      wr_q   <= acc && |hit;
      cs_q   <= acc ? hit : 4'b0;
      if (acc && |hit) begin
        addr_q <= off;
        din_q  <= i_DL_DATA;
      end
      if (wr_q) sum_q <= sum_q + din_q;
      case (state_q)
        IDLE, DONE: if (i_DL_ACT) begin
          state_q <= LOAD;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          sum_q   <= '0;
        end
        LOAD: begin
          if (i_DL_WR && wait_q) err_q <= 1'b1;
          if (!i_DL_ACT && !acc) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_DL_WAIT   = wait_q;
  assign o_PROG_ADDR = addr_q;
  assign o_PROG_DIN  = din_q;
  assign o_PROG_CS   = cs_q;
  assign o_PROG_WR   = wr_q;
  assign o_BUSY      = (state_q == LOAD);
  assign o_DONE      = done_q;
  assign o_ERR       = err_q;
  assign o_CHKSUM    = sum_q;
endmodule

// File: tb/tb_bubsysrom_prom_loader.sv
// tb_bubsysrom_prom_loader: directed + random stimulus against a transaction-level reference
module tb_bubsysrom_prom_loader;
  logic        clk = 0, rst = 0, act = 0, wr = 0;
  logic [23:0] addr = '0;
  logic [7:0]  data = '0;
  logic        dl_wait, prog_wr, busy, done, err;
  logic [9:0]  prog_addr;
  logic [7:0]  prog_din, chksum;
  logic [3:0]  prog_cs;
  int vectors = 0, miscompares = 0;
  localparam int BASE [4] = '{0, 1024, 2048, 3072};
  // reference: session mode 0=idle 1=loading 2=finished, plus expected visible outputs
  int m_mode = 0;
  int e_wait = 0, e_wr = 0, e_cs = 0, e_addr = 0, e_din = 0, e_done = 0, e_err = 0, e_sum = 0;

  bubsysrom_prom_loader dut (
    .i_MCLK(clk), .i_RST(rst), .i_DL_ACT(act), .i_DL_ADDR(addr), .i_DL_DATA(data),
    .i_DL_WR(wr), .o_DL_WAIT(dl_wait), .o_PROG_ADDR(prog_addr), .o_PROG_DIN(prog_din),
    .o_PROG_CS(prog_cs), .o_PROG_WR(prog_wr), .o_BUSY(busy), .o_DONE(done), .o_ERR(err),
    .o_CHKSUM(chksum));

  always #5 clk = ~clk;

  function automatic int region(int a_in);
    int r = -1;
    for (int n = 3; n >= 0; n--)
      if (a_in >= BASE[n] && a_in < BASE[n] + 1024) r = n;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("wait", 32'(dl_wait), 32'(e_wait));
    chk("prog_wr", 32'(prog_wr), 32'(e_wr));
    chk("prog_cs", 32'(prog_cs), 32'(e_cs));
    chk("prog_addr", 32'(prog_addr), 32'(e_addr));
    chk("prog_din", 32'(prog_din), 32'(e_din));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("chksum", 32'(chksum), 32'(e_sum));
  endtask

  task automatic cyc(input bit a_act, input bit a_wr, input int a_addr, input int a_data);
    int n;
    bit accept;
    act = a_act; wr = a_wr; addr = 24'(a_addr); data = 8'(a_data);
    accept = (m_mode == 1) && a_wr && !e_wait;
    n = region(a_addr);
    @(posedge clk);
    #1;
    if (e_wr) e_sum = (e_sum + e_din) % 256;
    if (m_mode != 1 && a_act) begin
      m_mode = 1; e_done = 0; e_err = 0; e_sum = 0;
    end else if (m_mode == 1) begin
      if (a_wr && e_wait) e_err = 1;
      if (!a_act && !accept) begin m_mode = 2; e_done = 1; end
    end
    e_wait = int'(accept);
    e_wr = int'(accept && n >= 0);
    e_cs = (accept && n >= 0) ? (1 << n) : 0;
    if (accept && n >= 0) begin
      e_addr = (a_addr - BASE[n]) % 1024;
      e_din = a_data;
    end
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; act = 1; wr = 1; addr = 24'd5; data = 8'hEE;
    @(posedge clk);
    #1;
    m_mode = 0; e_wait = 0; e_wr = 0; e_cs = 0; e_addr = 0; e_din = 0;
    e_done = 0; e_err = 0; e_sum = 0;
    check_all();
    rst = 0; act = 0; wr = 0;
  endtask

  initial begin
    do_reset();
    // single byte into region 1
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1030, 8'h5A);
    chk("s1_cs", 32'(prog_cs), 32'b0010);
    chk("s1_addr", 32'(prog_addr), 32'd6);
    cyc(1, 0, 0, 0);
    chk("s1_wr_once", 32'(prog_wr), 32'd0);
    chk("s1_sum", 32'(chksum), 32'h5A);
    // new session, one byte per region
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, i * 1024, i + 1);
      chk("s2_cs", 32'(prog_cs), 32'(1 << i));
      chk("s2_addr", 32'(prog_addr), 32'd0);
      cyc(1, 0, 0, 0);
    end
    chk("s2_sum", 32'(chksum), 32'h0A);
    chk("s2_err", 32'(err), 32'd0);
    // unmatched address, then strobe while waiting
    cyc(1, 1, 5000, 8'h77);
    chk("s3_nowr", 32'(prog_wr), 32'd0);
    cyc(1, 1, 10, 8'h33);
    chk("s3_err", 32'(err), 32'd1);
    cyc(1, 0, 0, 0);
    chk("s3_sum", 32'(chksum), 32'h0A);
    // ACT falls with the strobe
    cyc(0, 1, 1, 8'h99);
    chk("s4_wr", 32'(prog_wr), 32'd1);
    cyc(0, 0, 0, 0);
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_busy", 32'(busy), 32'd0);
    cyc(1, 0, 0, 0);
    chk("s4_clr", 32'({done, chksum}), 32'd0);
    // reset during T+1 cancels the write
    cyc(1, 1, 2, 8'h44);
    do_reset();
    chk("s5_wr", 32'(prog_wr), 32'd0);
    cyc(0, 1, 3, 8'h55);
    cyc(0, 0, 0, 0);
    chk("s5_idle", 32'({prog_wr, prog_cs, busy}), 32'd0);
    cyc(1, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
               int'($urandom_range(0, 5119)), int'($urandom_range(0, 255)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
